// File: rtl/hexdump_tx.sv
// Hex-dump UART transmitter: queues words and prints each as lowercase
// hex ASCII with optional leading-zero suppression and a trailer.
module hexdump_tx #(
   parameter int DIGIT = 8,
   parameter int WCNT  = 868,
   parameter int DEPTH = 4,
   parameter int STOPB = 1
) (
   input  logic               CLK,
   input  logic               RST_X,
   input  logic [DIGIT*4-1:0] DATA,
   input  logic [1:0]         SEP,
   input  logic               LZS,
   input  logic               WE,
   output logic               TXD,
   output logic               READY,
   output logic               BUSY,
   output logic               DROP
);

   localparam int DW = (DIGIT > 1) ? $clog2(DIGIT) : 1;
   localparam int CW = $clog2(WCNT);
   localparam int AW = $clog2(DEPTH);
   localparam int EW = DIGIT*4 + 3;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_START, S_BITS, S_STOP
   } state_t;

   logic [EW-1:0]      r_mem [DEPTH];
   logic [AW:0]        r_wp, r_rp;
   logic               r_drop;
   state_t             r_st, w_st_nx;
   logic [CW-1:0]      r_cnt, w_cnt_nx;
   logic [2:0]         r_bit, w_bit_nx;
   logic               r_sb, w_sb_nx;
   logic [DIGIT*4-1:0] r_word, w_word_nx;
   logic [1:0]         r_sep, w_sep_nx;
   logic [DW-1:0]      r_dig, w_dig_nx;
   logic [1:0]         r_ph, w_ph_nx;
   logic [7:0]         r_char, w_char_nx;

   logic               w_empty, w_full, w_push, w_pop;
   logic [EW-1:0]      w_head;
   logic [DIGIT*4-1:0] w_h_data;
   logic               w_h_lzs;
   logic [1:0]         w_h_sep;
   logic [DW-1:0]      w_first, w_dig_dn;
   logic [7:0]         w_tr0, w_tr1;
   logic               w_done, w_tick, w_pre, w_last_sb;

   function automatic logic [7:0] f_hex(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
   endfunction

   assign w_empty = (r_wp == r_rp);
   assign w_full  = (r_wp[AW] != r_rp[AW]) &&
                    (r_wp[AW-1:0] == r_rp[AW-1:0]);
   assign w_push  = WE && !w_full;
   assign w_pop   = (r_st == S_LOAD);
   assign w_head  = r_mem[r_rp[AW-1:0]];
   assign w_h_data = w_head[DIGIT*4-1:0];
   assign w_h_lzs  = w_head[DIGIT*4];
   assign w_h_sep  = w_head[EW-1 -: 2];

   assign READY = !w_full;
   assign BUSY  = (r_st != S_IDLE) || !w_empty;
   assign DROP  = r_drop;
   assign TXD   = (r_st == S_START) ? 1'b0 :
                  (r_st == S_BITS)  ? r_char[r_bit] : 1'b1;

   // Highest non-zero nibble; the LS nibble is always printed.
   always_comb begin
      w_first = DW'(DIGIT-1);
      if (w_h_lzs) begin
         w_first = '0;
         for (int i = 1; i < DIGIT; i++) begin
            if (w_h_data[4*i +: 4] != 4'h0) w_first = DW'(i);
         end
      end
   end

   assign w_dig_dn  = r_dig - 1'b1;
   assign w_tr0     = (r_sep == 2'b01) ? 8'h20 :
                      (r_sep == 2'b10) ? 8'h0D : 8'h2C;
   assign w_tr1     = r_sep[0] ? 8'h20 : 8'h0A;
   assign w_done    = (r_ph == 2'd0 && r_dig == '0 && r_sep == 2'b00) ||
                      (r_ph == 2'd1 && !r_sep[1]) ||
                      (r_ph == 2'd2);
   assign w_tick    = (r_cnt == CW'(WCNT-1));
   assign w_pre     = (r_cnt == CW'(WCNT-2));
   assign w_last_sb = (r_sb == 1'(STOPB-1));

   always_comb begin
      w_st_nx   = r_st;
      w_cnt_nx  = w_tick ? '0 : r_cnt + 1'b1;
      w_bit_nx  = r_bit;
      w_sb_nx   = r_sb;
      w_word_nx = r_word;
      w_sep_nx  = r_sep;
      w_dig_nx  = r_dig;
      w_ph_nx   = r_ph;
      w_char_nx = r_char;
      unique case (r_st)
         S_IDLE: begin
            w_cnt_nx = '0;
            if (!w_empty) w_st_nx = S_LOAD;
         end
         S_LOAD: begin
            w_cnt_nx  = '0;
            w_st_nx   = S_START;
            w_word_nx = w_h_data;
            w_sep_nx  = w_h_sep;
            w_dig_nx  = w_first;
            w_ph_nx   = 2'd0;
            w_char_nx = f_hex(w_h_data[4*w_first +: 4]);
         end
         S_START: begin
            if (w_tick) begin
               w_st_nx  = S_BITS;
               w_bit_nx = 3'd0;
            end
         end
         S_BITS: begin
            if (w_tick) begin
               if (r_bit == 3'd7) begin
                  w_st_nx = S_STOP;
                  w_sb_nx = 1'b0;
               end else begin
                  w_bit_nx = r_bit + 3'd1;
               end
            end
         end
         S_STOP: begin
            // LOAD borrows the last stop clock so words run gap-free.
            if (w_last_sb && w_pre && w_done && !w_empty) begin
               w_st_nx  = S_LOAD;
               w_cnt_nx = '0;
            end else if (w_tick) begin
               if (!w_last_sb) begin
                  w_sb_nx = 1'b1;
               end else if (w_done) begin
                  w_st_nx = S_IDLE;
               end else begin
                  w_st_nx = S_START;
                  if (r_ph == 2'd0 && r_dig != '0) begin
                     w_dig_nx  = w_dig_dn;
                     w_char_nx = f_hex(r_word[4*w_dig_dn +: 4]);
                  end else if (r_ph == 2'd0) begin
                     w_ph_nx   = 2'd1;
                     w_char_nx = w_tr0;
                  end else begin
                     w_ph_nx   = 2'd2;
                     w_char_nx = w_tr1;
                  end
               end
            end
         end
         default: w_st_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (w_push) r_mem[r_wp[AW-1:0]] <= {SEP, LZS, DATA};
   end

   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         r_wp   <= '0;
         r_rp   <= '0;
         r_drop <= 1'b0;
         r_st   <= S_IDLE;
         r_cnt  <= '0;
         r_bit  <= '0;
         r_sb   <= 1'b0;
         r_word <= '0;
         r_sep  <= '0;
         r_dig  <= '0;
         r_ph   <= '0;
         r_char <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + 1'b1;
         if (w_pop) r_rp <= r_rp + 1'b1;
         if (WE && w_full) r_drop <= 1'b1;
         r_st   <= w_st_nx;
         r_cnt  <= w_cnt_nx;
         r_bit  <= w_bit_nx;
         r_sb   <= w_sb_nx;
         r_word <= w_word_nx;
         r_sep  <= w_sep_nx;
         r_dig  <= w_dig_nx;
         r_ph   <= w_ph_nx;
         r_char <= w_char_nx;
      end
   end

endmodule

// File: tb/tb_hexdump_tx.sv
// Bench for hexdump_tx: frame-level UART monitor plus a string-based
// reference model; one instance with STOPB=1 and one with STOPB=2.
module tb_hexdump_tx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] data = '0;
   logic [1:0]  sep = '0;
   logic        lzs = 1'b0;
   logic        we = 1'b0;
   logic        sel = 1'b0;
   logic        txd1, rdy1, busy1, drop1;
   logic        txd2, rdy2, busy2, drop2;
   logic        mon_txd, mon_busy;
   int          cyc = 0;
   int          n_pass = 0;
   int          n_tot = 0;

   byte         rx_b[$];
   int          rx_t[$];
   bit          rx_ok[$];
   logic        smp[0:47];

   typedef struct packed {
      logic [31:0] d;
      logic [1:0]  s;
      logic        l;
      logic [79:0] e;
      logic [3:0]  n;
   } vec_t;
   vec_t vt[6];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign mon_txd  = sel ? txd2 : txd1;
   assign mon_busy = sel ? busy2 : busy1;

   hexdump_tx #(.DIGIT(8), .WCNT(4), .DEPTH(4), .STOPB(1)) u_dut1 (
      .CLK(clk), .RST_X(rst_n), .DATA(data), .SEP(sep), .LZS(lzs),
      .WE(we & !sel), .TXD(txd1), .READY(rdy1), .BUSY(busy1),
      .DROP(drop1)
   );

   hexdump_tx #(.DIGIT(8), .WCNT(4), .DEPTH(4), .STOPB(2)) u_dut2 (
      .CLK(clk), .RST_X(rst_n), .DATA(data), .SEP(sep), .LZS(lzs),
      .WE(we & sel), .TXD(txd2), .READY(rdy2), .BUSY(busy2),
      .DROP(drop2)
   );

   // Frame receiver: samples every clock of a frame so bit widths,
   // levels and start times are all checked, not just mid-bit values.
   initial begin : mon
      logic prev;
      int   f, sb, t0;
      bit   ab, ok;
      byte  b;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (rst_n && prev && !mon_txd) begin
            sb = sel ? 2 : 1;
            f  = (9 + sb) * 4;
            t0 = cyc;
            ab = 1'b0;
            for (int s = 0; s < f; s++) begin
               if (s > 0) @(negedge clk);
               if (!rst_n) ab = 1'b1;
               smp[s] = mon_txd;
            end
            ok = 1'b1;
            for (int k = 0; k < 9 + sb; k++) begin
               for (int j = 0; j < 4; j++)
                  if (smp[k*4+j] !== smp[k*4]) ok = 1'b0;
               if (k == 0 && smp[0] !== 1'b0) ok = 1'b0;
               if (k >= 9 && smp[k*4] !== 1'b1) ok = 1'b0;
            end
            b = 8'h00;
            for (int k = 0; k < 8; k++) b[k] = smp[(k+1)*4];
            if (!ab) begin
               rx_b.push_back(b);
               rx_t.push_back(t0);
               rx_ok.push_back(ok);
            end
         end
         prev = mon_txd;
      end
   end

   function automatic string model(logic [31:0] d, logic [1:0] s,
                                   logic l);
      string hexc = "0123456789abcdef";
      string r = "";
      bit seen = !l;
      int n;
      for (int i = 7; i >= 0; i--) begin
         n = int'((d >> (4*i)) & 32'hF);
         if (n != 0 || i == 0) seen = 1'b1;
         if (seen) r = $sformatf("%s%c", r, hexc[n]);
      end
      case (s)
         2'b01: r = {r, " "};
         2'b10: r = {r, "\r\n"};
         2'b11: r = {r, ", "};
         default: ;
      endcase
      return r;
   endfunction

   function automatic string p2s(logic [79:0] e, int n);
      string r = "";
      for (int k = 0; k < n; k++)
         r = $sformatf("%s%c", r, e[8*(n-1-k) +: 8]);
      return r;
   endfunction

   function automatic string hexs(string s);
      string r = "";
      for (int i = 0; i < s.len(); i++)
         r = $sformatf("%s%02h", r, s[i]);
      return r;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic chk_s(input string nm, input string act,
                        input string exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got hex[%s] expected hex[%s]",
                    nm, hexs(act), hexs(exp));
   endtask

   task automatic clear_rx();
      rx_b.delete();
      rx_t.delete();
      rx_ok.delete();
   endtask

   task automatic send(input logic [31:0] d, input logic [1:0] s,
                       input logic l, output int p);
      @(posedge clk);
      #1;
      data = d; sep = s; lzs = l; we = 1'b1;
      @(posedge clk);
      #1;
      we = 1'b0;
      p = cyc;
   endtask

   task automatic wait_check(input string nm, input int p,
                             input string exp, input int sb);
      int total, per, bad;
      string got;
      per   = (9 + sb) * 4;
      total = exp.len() * per;
      for (int i = 0; i < total + 20 && cyc < p + 1 + total; i++)
         @(negedge clk);
      chk({nm, ".busy_last"}, int'(mon_busy), 1);
      @(negedge clk);
      chk({nm, ".busy_end"}, int'(mon_busy), 0);
      chk({nm, ".txd_idle"}, int'(mon_txd), 1);
      got = "";
      foreach (rx_b[i]) got = $sformatf("%s%c", got, rx_b[i]);
      chk_s({nm, ".text"}, got, exp);
      if (rx_t.size() > 0) chk({nm, ".latency"}, rx_t[0] - p, 2);
      else chk({nm, ".latency"}, -1, 2);
      bad = 0;
      for (int i = 1; i < rx_t.size(); i++)
         if (rx_t[i] - rx_t[i-1] != per) bad++;
      foreach (rx_ok[i]) if (!rx_ok[i]) bad++;
      chk({nm, ".frame_gap"}, bad, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      clear_rx();
   endtask

   initial begin : main
      int p;
      string exp;
      logic [31:0] bw[6];
      logic [1:0]  bs[6];
      logic        bl[6];

      vt[0] = '{32'h1234ABCD, 2'b01, 1'b0, 80'("1234abcd "), 4'd9};
      vt[1] = '{32'h0000F00A, 2'b10, 1'b1, 80'("f00a\r\n"), 4'd6};
      vt[2] = '{32'h00000000, 2'b00, 1'b1, 80'("0"), 4'd1};
      vt[3] = '{32'h00000000, 2'b11, 1'b0, 80'("00000000, "), 4'd10};
      vt[4] = '{32'h000C0FFE, 2'b11, 1'b1, 80'("c0ffe, "), 4'd7};
      vt[5] = '{32'h80000000, 2'b00, 1'b1, 80'("80000000"), 4'd8};

      #2 rst_n = 1'b0;
      #10;
      chk("rst.txd", int'(txd1), 1);
      chk("rst.ready", int'(rdy1), 1);
      chk("rst.busy", int'(busy1), 0);
      chk("rst.drop", int'(drop1), 0);
      chk("rst.txd2", int'(txd2), 1);
      chk("rst.ready2", int'(rdy2), 1);
      chk("rst.drop2", int'(drop2), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst.busy", int'(busy1), 0);

      for (int i = 0; i < 6; i++) begin
         clear_rx();
         send(vt[i].d, vt[i].s, vt[i].l, p);
         wait_check($sformatf("vec%0d", i), p,
                    p2s(vt[i].e, int'(vt[i].n)), 1);
      end

      for (int i = 0; i < 4; i++) begin
         bw[0] = $urandom;
         if ($urandom_range(0, 1) == 1) bw[0] = bw[0] >> (4 * $urandom_range(1, 7));
         bs[0] = 2'($urandom_range(0, 3));
         bl[0] = 1'($urandom_range(0, 1));
         clear_rx();
         send(bw[0], bs[0], bl[0], p);
         wait_check($sformatf("rnd%0d", i), p,
                    model(bw[0], bs[0], bl[0]), 1);
      end

      do_reset();
      for (int i = 0; i < 6; i++) begin
         bw[i] = $urandom >> (4 * $urandom_range(0, 4));
         bs[i] = 2'($urandom_range(0, 3));
         bl[i] = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1;
      data = bw[0]; sep = bs[0]; lzs = bl[0]; we = 1'b1;
      p = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         if (i == 0) p = cyc;
         if (i == 3) chk("burst.ready4", int'(rdy1), 1);
         if (i == 4) begin
            chk("burst.ready5", int'(rdy1), 0);
            chk("burst.drop5", int'(drop1), 0);
         end
         if (i == 5) chk("burst.drop6", int'(drop1), 1);
         if (i < 5) begin
            data = bw[i+1]; sep = bs[i+1]; lzs = bl[i+1];
         end else begin
            we = 1'b0;
         end
      end
      exp = "";
      for (int i = 0; i < 5; i++) exp = {exp, model(bw[i], bs[i], bl[i])};
      wait_check("burst", p, exp, 1);
      chk("burst.drop_sticky", int'(drop1), 1);

      do_reset();
      chk("rst.drop_clear", int'(drop1), 0);
      sel = 1'b1;
      send(32'h1234ABCD, 2'b01, 1'b0, p);
      wait_check("stopb2", p, "1234abcd ", 2);
      sel = 1'b0;

      do_reset();
      send(32'h1234ABCD, 2'b01, 1'b0, p);
      for (int i = 0; i < 100 && cyc < p + 55; i++) @(negedge clk);
      chk("abort.txd_before", int'(txd1), 0);
      rst_n = 1'b0;
      #1;
      chk("abort.txd", int'(txd1), 1);
      chk("abort.busy", int'(busy1), 0);
      chk("abort.ready", int'(rdy1), 1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (200) @(negedge clk);
      chk("abort.nchars", rx_b.size(), 1);
      if (rx_b.size() > 0) chk("abort.char0", int'(rx_b[0]), 8'h31);
      else chk("abort.char0", -1, 8'h31);
      chk("abort.busy_after", int'(busy1), 0);
      chk("abort.txd_after", int'(txd1), 1);

      clear_rx();
      send(32'h0000F00A, 2'b10, 1'b1, p);
      wait_check("after_abort", p, "f00a\r\n", 1);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
